da_conv_col: RTL and testbench

//   Bit-serial distributed-arithmetic (DA) column convolver: the multi-bit, sequential successor of the

---
 rtl/da_pkg.sv | 22 ++
 rtl/da_lut_sum.sv | 33 +++
 rtl/da_conv_col.sv | 122 ++++++++++++
 tb/tb_da_conv_col.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared types and elaboration helpers for the distributed-arithmetic column convolver.
package da_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } da_state_t;

    // Full-precision result width: sample x weight product plus tap-count growth plus sign.
    function automatic int unsigned da_acc_w(input int unsigned data_w,
                                             input int unsigned weight_w,
                                             input int unsigned kernel_h);
        return data_w + weight_w + 32'($clog2(kernel_h)) + 32'd1;
    endfunction

    function automatic int unsigned da_num_luts(input int unsigned kernel_h,
                                                input int unsigned lut_in);
        return (kernel_h + lut_in - 32'd1) / lut_in;
    endfunction

endpackage

// File: rtl/da_lut_sum.sv
// Combinational DA partition: ROM of all partial weight sums for one LUT_IN-tap bit slice.
module da_lut_sum #(
    parameter int unsigned LUT_IN = 4,
    parameter int unsigned WEIGHT_W = 5,
    parameter int unsigned NTAPS = LUT_IN,
    parameter logic [LUT_IN*WEIGHT_W-1:0] W_SLICE = '0,
    localparam int unsigned OUT_W = WEIGHT_W + $clog2(LUT_IN) + 1
) (
    input  logic [LUT_IN-1:0]       d,
    output logic signed [OUT_W-1:0] sum
);

    // Taps at or above NTAPS are padding and never contribute.
    function automatic int lut_entry(input int unsigned addr);
        int acc;
        logic signed [WEIGHT_W-1:0] w;
        acc = 0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            w = W_SLICE[i*WEIGHT_W +: WEIGHT_W];
            if (addr[i]) acc += int'(w);
        end
        return acc;
    endfunction

    logic signed [OUT_W-1:0] rom [2**LUT_IN];

    for (genvar a = 0; a < 2**LUT_IN; a++) begin : g_rom
        assign rom[a] = OUT_W'(lut_entry(a));
    end

    assign sum = rom[d];

endmodule

// File: rtl/da_conv_col.sv
// Bit-serial DA column convolver: one KERNEL_H-tap dot product per accepted column, MSB-first.
module da_conv_col
    import da_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned KERNEL_H = 7,
    parameter int unsigned WEIGHT_W = 5,
    parameter logic [KERNEL_H*WEIGHT_W-1:0] WEIGHTS = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1},
    parameter int unsigned LUT_IN = 4,
    parameter bit SIGNED_IN = 1'b0,
    localparam int unsigned ACC_W = da_acc_w(DATA_W, WEIGHT_W, KERNEL_H)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [KERNEL_H*DATA_W-1:0] in_col,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    out_sum
);

    localparam int unsigned NUM_LUTS = da_num_luts(KERNEL_H, LUT_IN);
    localparam int unsigned PAD_H = NUM_LUTS * LUT_IN;
    localparam int unsigned PAD_BITS = PAD_H * WEIGHT_W;
    localparam int unsigned LUT_OW = WEIGHT_W + $clog2(LUT_IN) + 1;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [PAD_BITS-1:0] W_PAD = PAD_BITS'(WEIGHTS);

    da_state_t                   state, state_nxt;
    logic                        xfer, last;
    logic [CNT_W-1:0]            bit_cnt;
    logic [KERNEL_H*DATA_W-1:0]  shift_q, shift_nxt;
    logic [PAD_H-1:0]            d_pad;
    logic signed [LUT_OW-1:0]    lut_out [NUM_LUTS];
    logic signed [ACC_W-1:0]     p, acc_q, acc_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (xfer) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded handshake and control
    always_comb begin
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
        xfer     = in_valid && in_ready;
        last     = (state == RUN) && (bit_cnt == CNT_W'(DATA_W - 1));
    end

    // Current bit slice (tap MSBs), zero-padded to whole LUT partitions, and per-tap shift
    always_comb begin
        d_pad     = '0;
        shift_nxt = '0;
        for (int unsigned t = 0; t < KERNEL_H; t++) begin
            d_pad[t] = shift_q[t*DATA_W + DATA_W - 1];
            shift_nxt[t*DATA_W +: DATA_W] = {shift_q[t*DATA_W +: DATA_W-1], 1'b0};
        end
    end

    for (genvar g = 0; g < NUM_LUTS; g++) begin : g_lut
        localparam int unsigned NT = (KERNEL_H - g*LUT_IN < LUT_IN) ? (KERNEL_H - g*LUT_IN) : LUT_IN;
        da_lut_sum #(
            .LUT_IN  (LUT_IN),
            .WEIGHT_W(WEIGHT_W),
            .NTAPS   (NT),
            .W_SLICE (W_PAD[g*LUT_IN*WEIGHT_W +: LUT_IN*WEIGHT_W])
        ) u_lut (
            .d  (d_pad[g*LUT_IN +: LUT_IN]),
            .sum(lut_out[g])
        );
    end

    // Partial-sum reduction and shift-accumulate; first slice is negative for signed samples
    always_comb begin
        p = '0;
        for (int unsigned g = 0; g < NUM_LUTS; g++) begin
            p = p + ACC_W'(lut_out[g]);
        end
        if (SIGNED_IN && (bit_cnt == '0)) acc_nxt = -p;
        else                              acc_nxt = (acc_q <<< 1) + p;
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            acc_q     <= '0;
            bit_cnt   <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else begin
            if (xfer) begin
                shift_q <= in_col;
                acc_q   <= '0;
                bit_cnt <= '0;
            end else if (state == RUN) begin
                shift_q <= shift_nxt;
                acc_q   <= acc_nxt;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (last) begin
                out_valid <= 1'b1;
                out_sum   <= acc_nxt;
            end else if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_da_conv_col.sv
// Scoreboard bench: five parameterisations of da_conv_col share one stimulus stream.
module tb_da_conv_col;

    localparam int unsigned NDUT  = 5;
    localparam int unsigned ACC_W = 17;
    localparam logic [34:0] W_DEF = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [34:0] W_NEG = 35'(5'b10000);
    localparam logic [24:0] W_K5  = {5'b11101, 5'b00111, 5'b11000, 5'b00010, 5'b00101};

    typedef logic [NDUT-1:0][31:0] exp_t;

    logic clk = 1'b0;
    logic rst_n, in_valid, out_ready;
    logic [55:0] in_col;
    logic [NDUT-1:0] in_ready, out_valid;
    logic signed [ACC_W-1:0] out_sum [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: default unsigned, 1: default signed, 2: tap0=-16 signed, 3: tap0=-16 unsigned, 4: K=5/LUT_IN=3 signed
    da_conv_col #(.SIGNED_IN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .in_col(in_col),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_sum(out_sum[0]));
    da_conv_col #(.SIGNED_IN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .in_col(in_col),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_sum(out_sum[1]));
    da_conv_col #(.WEIGHTS(W_NEG), .SIGNED_IN(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .in_col(in_col),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_sum(out_sum[2]));
    da_conv_col #(.WEIGHTS(W_NEG), .SIGNED_IN(1'b0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[3]), .in_col(in_col),
        .out_valid(out_valid[3]), .out_ready(out_ready), .out_sum(out_sum[3]));
    da_conv_col #(.KERNEL_H(5), .WEIGHTS(W_K5), .LUT_IN(3), .SIGNED_IN(1'b1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[4]), .in_col(in_col[39:0]),
        .out_valid(out_valid[4]), .out_ready(out_ready), .out_sum(out_sum[4]));

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural dot product over the first k taps
    function automatic int dot(input logic [55:0] col, input logic [34:0] w, input int k, input bit sgn);
        int s;
        logic [7:0] b;
        logic signed [4:0] ws;
        s = 0;
        for (int t = 0; t < k; t++) begin
            b  = col[t*8 +: 8];
            ws = w[t*5 +: 5];
            s += (sgn ? int'($signed(b)) : int'(b)) * int'(ws);
        end
        return s;
    endfunction

    function automatic logic [55:0] rep(input logic [7:0] b);
        return {7{b}};
    endfunction

    function automatic exp_t mk(input int v0, input int v1, input int v2, input int v3, input int v4);
        exp_t e;
        e[0] = v0; e[1] = v1; e[2] = v2; e[3] = v3; e[4] = v4;
        return e;
    endfunction

    // Present a column until accepted; acc_cyc is the cycle number of the accepting edge
    task automatic issue(input logic [55:0] col, input exp_t e, input bit push, output int acc_cyc);
        int n;
        in_col = col;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        n = 0;
        while (!in_ready[0] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("accept_timeout", n, 0);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid != '0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
    endtask

    // Monitor: compare every accepted result against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (out_valid != '0 && out_ready && rst_n) begin
            chk("valid_lockstep", int'(out_valid), 31);
            if (exp_q.size() == 0) begin
                chk("unexpected_result", int'(out_sum[0]), 0);
                chk("unexpected_valid", int'(out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                for (int i = 0; i < NDUT; i++)
                    chk($sformatf("sum_dut%0d", i), int'(out_sum[i]), int'(e[i]));
            end
        end
    end

    initial begin
        int a, a1, a2, a3, n;
        bit ok, rdy_ok, vld_ok;
        logic signed [ACC_W-1:0] held;
        logic [55:0] col;

        rst_n = 1'b0; in_valid = 1'b0; in_col = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 31);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_sum", int'(out_sum[0]), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency and in_ready during RUN
        issue(rep(8'd1), mk(28, 28, -16, -16, 3), 1'b1, a);
        ok = 1'b1; n = 0;
        while (!out_valid[0] && n < 20) begin
            if (in_ready[0]) ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk("latency", cyc - a, 8);
        chk("run_in_ready_low", int'(ok), 1);
        drain();

        // Sign handling and boundary samples
        issue(rep(8'hFF), mk(7140, -28, 16, -4080, -3), 1'b1, a);
        issue(56'h80, mk(128, -128, 2048, -2048, -640), 1'b1, a);
        issue(56'hFF, mk(255, -1, 16, -4080, -5), 1'b1, a);
        issue(rep(8'h7F), mk(3556, 3556, -2032, -2032, 381), 1'b1, a);
        issue(rep(8'h80), mk(3584, -3584, 2048, -2048, -384), 1'b1, a);
        issue({8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, mk(140, 140, -16, -16, -2), 1'b1, a);
        drain();

        // Back-to-back throughput
        issue(rep(8'd1), mk(28, 28, -16, -16, 3), 1'b1, a1);
        issue(rep(8'd2), mk(56, 56, -32, -32, 6), 1'b1, a2);
        issue(rep(8'd3), mk(84, 84, -48, -48, 9), 1'b1, a3);
        chk("throughput_1_2", a2 - a1, 9);
        chk("throughput_2_3", a3 - a2, 9);
        drain();

        // Backpressure in DONE with a competing column offered
        out_ready = 1'b0;
        issue(rep(8'd2), mk(56, 56, -32, -32, 6), 1'b1, a);
        n = 0;
        while (!out_valid[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        held = out_sum[0];
        in_col = rep(8'd3);
        in_valid = 1'b1;
        exp_q.push_back(mk(84, 84, -48, -48, 9));
        ok = 1'b1; rdy_ok = 1'b1; vld_ok = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_sum[0] != held) ok = 1'b0;
            if (out_valid != '1) vld_ok = 1'b0;
            if (in_ready != '0) rdy_ok = 1'b0;
        end
        chk("bp_sum_stable", int'(ok), 1);
        chk("bp_valid_held", int'(vld_ok), 1);
        chk("bp_in_ready_low", int'(rdy_ok), 1);
        chk("bp_held_value", int'(held), 56);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_reload_run", int'(in_ready[0]), 0);
        drain();

        // Reset in mid-RUN discards the column
        issue(rep(8'h55), mk(0, 0, 0, 0, 0), 1'b0, a);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid != '0 || in_ready != '1) ok = 1'b0;
        end
        chk("reset_discard", int'(ok), 1);
        issue(rep(8'd1), mk(28, 28, -16, -16, 3), 1'b1, a);
        drain();

        // Random columns against the behavioural model
        for (int r = 0; r < 20; r++) begin
            col = {$urandom(), $urandom()} & 56'hFF_FFFF_FFFF_FFFF;
            issue(col, mk(dot(col, W_DEF, 7, 1'b0), dot(col, W_DEF, 7, 1'b1),
                          dot(col, W_NEG, 7, 1'b1), dot(col, W_NEG, 7, 1'b0),
                          dot(col, 35'(W_K5), 5, 1'b1)), 1'b1, a);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
